// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline stage: EX/MEM payload layout and fill states.
package pipe_pkg;

    localparam int EXMEM_PAYLOAD_W = 72;

    // EX/MEM payload layout, MSB first: {regWrite, memToReg, memWrite, aluResult[31:0], writeReg[4:0], writeData[31:0]}
    localparam int WDATA_LSB    = 0;
    localparam int WREG_LSB     = 32;
    localparam int ALURES_LSB   = 37;
    localparam int MEMWRITE_BIT = 69;
    localparam int MEMTOREG_BIT = 70;
    localparam int REGWRITE_BIT = 71;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fill_state_t;

    function automatic logic [1:0] fill_count(input fill_state_t s);
        logic [1:0] c;
        case (s)
            EMPTY:   c = 2'd0;
            ONE:     c = 2'd1;
            FULL:    c = 2'd2;
            default: c = 2'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_stage_hs_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream (in_*) and downstream (out_*) sides.
interface pipe_stage_hs_if #(
    parameter int PAYLOAD_W = 72
);
    logic                 in_valid;
    logic                 in_ready;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 in_halt;
    logic                 out_valid;
    logic                 out_ready;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 out_halt;

    // The stage itself.
    modport slave (
        input  in_valid, in_payload, in_halt, out_ready,
        output in_ready, out_valid, out_payload, out_halt
    );

    // The surrounding pipeline (producer on in_*, consumer on out_*).
    modport master (
        output in_valid, in_payload, in_halt, out_ready,
        input  in_ready, out_valid, out_payload, out_halt
    );
endinterface

// File: rtl/pipe_sat_ctr.sv
// Saturating up-counter with increment enable; sticks at all-ones until synchronous reset.
module pipe_sat_ctr #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] countReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            countReg <= '0;
        end else if (inc && (countReg != {CNT_W{1'b1}})) begin
            countReg <= countReg + CNT_W'(1);
        end
    end

    assign count = countReg;

endmodule

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline stage with 2-entry skid buffer, flush and sticky halt capture.
// Optional stall/bubble performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = EXMEM_PAYLOAD_W,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_hs_if.slave   hs,
    output logic [1:0]       occupancy,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    fill_state_t          fillStateReg;
    logic [PAYLOAD_W-1:0] mainPayloadReg;
    logic [PAYLOAD_W-1:0] skidPayloadReg;
    logic                 mainHaltReg;
    logic                 skidHaltReg;
    logic                 haltedReg;

    logic mainValid;
    logic skidValid;
    logic inReady;
    logic accept;
    logic pop;

    // Valid bits are decoded from the fill state so they can never disagree with it.
    assign mainValid = (fillStateReg != EMPTY);
    assign skidValid = (fillStateReg == FULL);
    assign inReady   = ~skidValid & ~haltedReg;
    assign accept    = hs.in_valid & inReady;
    assign pop       = mainValid & hs.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            fillStateReg   <= EMPTY;
            mainPayloadReg <= '0;
            skidPayloadReg <= '0;
            mainHaltReg    <= 1'b0;
            skidHaltReg    <= 1'b0;
            haltedReg      <= 1'b0;
        end else begin
            if (flush) begin
                // Stale payloads stay put; only validity is dropped.
                fillStateReg <= EMPTY;
            end else begin
                case (fillStateReg)
                    EMPTY: begin
                        if (accept) begin
                            mainPayloadReg <= hs.in_payload;
                            mainHaltReg    <= hs.in_halt;
                            fillStateReg   <= ONE;
                        end
                    end
                    ONE: begin
                        if (accept && pop) begin
                            mainPayloadReg <= hs.in_payload;
                            mainHaltReg    <= hs.in_halt;
                        end else if (accept) begin
                            skidPayloadReg <= hs.in_payload;
                            skidHaltReg    <= hs.in_halt;
                            fillStateReg   <= FULL;
                        end else if (pop) begin
                            fillStateReg   <= EMPTY;
                        end
                    end
                    FULL: begin
                        // in_ready is low here, so only a pop can happen.
                        if (pop) begin
                            mainPayloadReg <= skidPayloadReg;
                            mainHaltReg    <= skidHaltReg;
                            fillStateReg   <= ONE;
                        end
                    end
                    default: fillStateReg <= EMPTY;
                endcase
            end
            if (accept && hs.in_halt && !flush) begin
                haltedReg <= 1'b1;
            end
        end
    end

    assign hs.in_ready    = inReady;
    assign hs.out_valid   = mainValid;
    assign hs.out_payload = mainPayloadReg;
    assign hs.out_halt    = mainHaltReg;
    assign occupancy      = fill_count(fillStateReg);
    assign halted         = haltedReg;

`ifdef PIPE_STAGE_PERF_EN
    logic [1:0]       perfInc;
    logic [CNT_W-1:0] perfCnt [2];

    // Index 0 counts stalls (held by downstream), index 1 counts bubbles (nothing to offer).
    assign perfInc[0] = mainValid & ~hs.out_ready;
    assign perfInc[1] = ~mainValid;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            pipe_sat_ctr #(
                .CNT_W (CNT_W)
            ) u_ctr (
                .clk   (clk),
                .reset (reset),
                .inc   (perfInc[gi]),
                .count (perfCnt[gi])
            );
        end
    endgenerate

    assign stall_cnt  = perfCnt[0];
    assign bubble_cnt = perfCnt[1];
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Self-checking bench for pipe_stage_hs: directed table, hand sequences and random traffic
// checked against a queue-based reference model.
module tb_pipe_stage_hs;

    localparam int PW = 72;
    localparam int CW = 4;
`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int CNT_MAX = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [1:0]    occupancy;
    logic          halted;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;

    pipe_stage_hs_if #(.PAYLOAD_W(PW)) hs ();

    pipe_stage_hs #(
        .PAYLOAD_W (PW),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .hs         (hs.slave),
        .occupancy  (occupancy),
        .halted     (halted),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a FIFO of at most two entries plus a sticky halt flag.
    typedef struct {
        logic [PW-1:0] p;
        logic          h;
    } ent_t;
    ent_t mq[$];
    bit   mHalted;
    int   mStall;
    int   mBubble;

    typedef struct {
        logic          inValid;
        logic [PW-1:0] pay;
        logic          outReady;
        logic          fl;
        logic          expValid;
        logic          expReady;
        logic [1:0]    expOcc;
        logic [PW-1:0] expPay;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [PW-1:0] p, input bit h, input bit r, input bit f);
        hs.in_valid   = v;
        hs.in_payload = p;
        hs.in_halt    = h;
        hs.out_ready  = r;
        flush         = f;
    endtask

    task automatic modelCheck(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".out_valid"}, PW'(hs.out_valid), PW'(n > 0));
        chk({tag, ".in_ready"}, PW'(hs.in_ready), PW'((n < 2) && !mHalted));
        chk({tag, ".occupancy"}, PW'(occupancy), PW'(n));
        chk({tag, ".halted"}, PW'(halted), PW'(mHalted));
        if (n > 0) begin
            chk({tag, ".out_payload"}, hs.out_payload, mq[0].p);
            chk({tag, ".out_halt"}, PW'(hs.out_halt), PW'(mq[0].h));
        end
        chk({tag, ".stall_cnt"}, PW'(stall_cnt), PW'(mStall));
        chk({tag, ".bubble_cnt"}, PW'(bubble_cnt), PW'(mBubble));
    endtask

    // Advance the model with the inputs currently driven, then clock the DUT.
    task automatic stepCycle();
        bit   v;
        bit   rdy;
        bit   acc;
        bit   pp;
        ent_t e;
        v   = (mq.size() > 0);
        rdy = (mq.size() < 2) && !mHalted;
        acc = hs.in_valid && rdy;
        pp  = v && hs.out_ready;
        if (reset) begin
            mq.delete();
            mHalted = 0;
            mStall  = 0;
            mBubble = 0;
        end else begin
            if (PERF && v && !hs.out_ready && mStall < CNT_MAX) mStall++;
            if (PERF && !v && mBubble < CNT_MAX) mBubble++;
            if (flush) begin
                mq.delete();
            end else begin
                if (pp) void'(mq.pop_front());
                if (acc) begin
                    e.p = hs.in_payload;
                    e.h = hs.in_halt;
                    mq.push_back(e);
                end
            end
            if (acc && hs.in_halt && !flush) mHalted = 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [95:0] rnd;

        // Backpressure + flush table, starting from an empty stage; expectations are post-edge.
        tbl[0]  = '{1'b1, 72'h11, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 72'h11};
        tbl[1]  = '{1'b1, 72'h22, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 72'h11};
        tbl[2]  = '{1'b1, 72'h44, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 72'h11};
        tbl[3]  = '{1'b1, 72'h44, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 72'h22};
        tbl[4]  = '{1'b1, 72'h44, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 72'h44};
        tbl[5]  = '{1'b0, 72'h00, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 72'h44};
        tbl[6]  = '{1'b1, 72'h55, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 72'h44};
        tbl[7]  = '{1'b1, 72'h33, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 72'h00};
        tbl[8]  = '{1'b1, 72'h66, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 72'h66};
        tbl[9]  = '{1'b1, 72'h77, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 72'h00};
        tbl[10] = '{1'b0, 72'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 72'h00};

        mHalted = 0;
        mStall  = 0;
        mBubble = 0;
        reset   = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        stepCycle();
        reset = 1'b0;

        // Reset state
        chk("reset.out_valid", PW'(hs.out_valid), '0);
        chk("reset.in_ready", PW'(hs.in_ready), PW'(1));
        chk("reset.occupancy", PW'(occupancy), '0);
        chk("reset.out_payload", hs.out_payload, '0);
        chk("reset.out_halt", PW'(hs.out_halt), '0);
        chk("reset.halted", PW'(halted), '0);

        // Streaming at full throughput
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, PW'(i), 1'b0, 1'b1, 1'b0);
            modelCheck("stream");
            stepCycle();
            chk("stream.payload", hs.out_payload, PW'(i));
            chk("stream.occupancy", PW'(occupancy), PW'(1));
            chk("stream.in_ready", PW'(hs.in_ready), PW'(1));
            $display("stream: sent %0d, out_payload=%0h", i, hs.out_payload);
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        modelCheck("drain");
        stepCycle();

        // Backpressure and flush vectors
        for (int k = 0; k < 11; k++) begin
            drive(tbl[k].inValid, tbl[k].pay, 1'b0, tbl[k].outReady, tbl[k].fl);
            modelCheck("tbl");
            stepCycle();
            chk($sformatf("tbl%0d.out_valid", k), PW'(hs.out_valid), PW'(tbl[k].expValid));
            chk($sformatf("tbl%0d.in_ready", k), PW'(hs.in_ready), PW'(tbl[k].expReady));
            chk($sformatf("tbl%0d.occupancy", k), PW'(occupancy), PW'(tbl[k].expOcc));
            if (tbl[k].expValid) chk($sformatf("tbl%0d.out_payload", k), hs.out_payload, tbl[k].expPay);
            $display("tbl%0d: in_valid=%0b in=%0h out_ready=%0b flush=%0b -> out_valid=%0b out=%0h occ=%0d",
                     k, tbl[k].inValid, tbl[k].pay, tbl[k].outReady, tbl[k].fl,
                     hs.out_valid, hs.out_payload, occupancy);
        end

        // Halt capture: E accepted, nothing after it
        drive(1'b1, 72'hEE, 1'b1, 1'b0, 1'b0);
        modelCheck("halt");
        stepCycle();
        chk("halt.halted", PW'(halted), PW'(1));
        chk("halt.in_ready", PW'(hs.in_ready), '0);
        chk("halt.out_halt", PW'(hs.out_halt), PW'(1));
        chk("halt.out_payload", hs.out_payload, 72'hEE);
        $display("halt: E presented out=%0h out_halt=%0b halted=%0b", hs.out_payload, hs.out_halt, halted);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 72'hF0, 1'b0, 1'b1, 1'b0);
            modelCheck("halt.post");
            stepCycle();
        end
        chk("halt.occ_after", PW'(occupancy), '0);
        chk("halt.ready_after", PW'(hs.in_ready), '0);
        $display("halt: after drain occ=%0d in_ready=%0b", occupancy, hs.in_ready);

        // Reset while FULL and halted
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        reset = 1'b0;
        drive(1'b1, 72'hAB, 1'b0, 1'b0, 1'b0);
        stepCycle();
        drive(1'b1, 72'hCD, 1'b1, 1'b0, 1'b0);
        stepCycle();
        chk("full_halt.occupancy", PW'(occupancy), PW'(2));
        chk("full_halt.halted", PW'(halted), PW'(1));
        reset = 1'b1;
        drive(1'b1, 72'h99, 1'b0, 1'b0, 1'b0);
        stepCycle();
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("rst2.out_valid", PW'(hs.out_valid), '0);
        chk("rst2.in_ready", PW'(hs.in_ready), PW'(1));
        chk("rst2.occupancy", PW'(occupancy), '0);
        chk("rst2.out_payload", hs.out_payload, '0);
        chk("rst2.out_halt", PW'(hs.out_halt), '0);
        chk("rst2.halted", PW'(halted), '0);
        chk("rst2.stall_cnt", PW'(stall_cnt), '0);
        $display("reset: mid-operation reset returned occ=%0d in_ready=%0b", occupancy, hs.in_ready);

        // Stall counter saturation
        drive(1'b1, 72'h5A, 1'b0, 1'b0, 1'b0);
        modelCheck("stall");
        stepCycle();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
            modelCheck("stall");
            stepCycle();
        end
        chk("stall.saturate", PW'(stall_cnt), PERF ? PW'(CNT_MAX) : '0);
        $display("stall: stall_cnt=%0d bubble_cnt=%0d", stall_cnt, bubble_cnt);

        // Random traffic against the model
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        reset = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            reset = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 3) != 0, rnd[PW-1:0], $urandom_range(0, 39) == 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            modelCheck("rand");
            stepCycle();
        end
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        modelCheck("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
